// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream load, fetch read and status signals of imem_loader
interface imem_loader_if #(parameter int DEPTH_WORDS = 1024);
  localparam int CW = $clog2(DEPTH_WORDS) + 1;
  logic ld_valid;
  logic [7:0] ld_data;
  logic ld_last;
  logic ld_ready;
  logic [63:0] address;
  logic [31:0] instruction;
  logic fetch_fault;
  logic cpu_hold;
  logic load_done;
  logic load_error;
  logic [CW-1:0] word_count;
  modport master (
    output ld_valid, ld_data, ld_last, address,
    input ld_ready, instruction, fetch_fault, cpu_hold, load_done, load_error, word_count
  );
  modport slave (
    input ld_valid, ld_data, ld_last, address,
    output ld_ready, instruction, fetch_fault, cpu_hold, load_done, load_error, word_count
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: instruction memory loaded from a little-endian byte stream, combinational fetch port
module imem_loader #(
  parameter int DEPTH_WORDS = 1024
) (
  input logic clk,
  input logic reset_n,
  imem_loader_if.slave bus
);
  localparam int CW = $clog2(DEPTH_WORDS) + 1;
  typedef enum logic [1:0] {LOAD, RUN, ERR} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [CW-1:0] wc_q, wc_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic acc, full, wr, hit;
  logic [CW-2:0] idx;
  always_comb begin
    acc = state_q == LOAD && bus.ld_valid;
    full = wc_q == CW'(DEPTH_WORDS);
    wr = reset_n && acc && !full && cnt_q == 2'd3;
    state_d = state_q;
    cnt_d = cnt_q;
    wc_d = wc_q;
    asm_d = asm_q;
    if (acc) begin
      if (full || (bus.ld_last && cnt_q != 2'd3)) begin
        state_d = ERR;
      end else if (cnt_q == 2'd3) begin
        wc_d = wc_q + CW'(1);
        cnt_d = 2'd0;
        state_d = bus.ld_last ? RUN : LOAD;
      end else begin
        cnt_d = cnt_q + 2'd1;
        asm_d = {cnt_q == 2'd2 ? bus.ld_data : asm_q[23:16],
                 cnt_q == 2'd1 ? bus.ld_data : asm_q[15:8],
                 cnt_q == 2'd0 ? bus.ld_data : asm_q[7:0]};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= LOAD;
      cnt_q <= 2'd0;
      wc_q <= '0;
      asm_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      wc_q <= wc_d;
      asm_q <= asm_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wc_q[CW-2:0]] <= {bus.ld_data, asm_q};
  end
  always_comb begin
    idx = bus.address[CW:2];
    hit = state_q == RUN && bus.address[1:0] == 2'd0 && bus.address[63:CW+1] == '0 && {1'b0, idx} < wc_q;
  end
  assign bus.instruction = hit ? mem[idx] : 32'h0;
  assign bus.fetch_fault = state_q == RUN && !hit;
  assign bus.ld_ready = state_q == LOAD;
  assign bus.cpu_hold = state_q != RUN;
  assign bus.load_done = state_q == RUN;
  assign bus.load_error = state_q == ERR;
  assign bus.word_count = wc_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven fetch checks plus scoreboarded program loads and corner sequences
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];
  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic fault;
  } fetch_vec_t;
  fetch_vec_t tv [7];
  logic [7:0] prog [8];
  imem_loader_if #(.DEPTH_WORDS(1024)) b ();
  imem_loader_if #(.DEPTH_WORDS(4)) b4 ();
  imem_loader #(.DEPTH_WORDS(1024)) u0 (.clk(clk), .reset_n(reset_n), .bus(b));
  imem_loader #(.DEPTH_WORDS(4)) u4 (.clk(clk), .reset_n(reset_n), .bus(b4));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  task automatic send(input logic [7:0] d, input logic last, input int gap);
    b.ld_valid = 1'b1;
    b.ld_data = d;
    b.ld_last = last;
    @(posedge clk);
    #1;
    b.ld_valid = 1'b0;
    b.ld_last = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic load_prog(input int gap);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) begin
      w = {prog[i], w[31:8]};
      if (i % 4 == 3) exp_q.push_back(w);
      send(prog[i], i == 7, gap);
    end
  endtask
  task automatic check_run(input string tag);
    int n;
    chk({tag, "_wc"}, 64'(b.word_count), 64'd2);
    chk({tag, "_done"}, 64'(b.load_done), 64'd1);
    chk({tag, "_hold"}, 64'(b.cpu_hold), 64'd0);
    chk({tag, "_ready"}, 64'(b.ld_ready), 64'd0);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      b.address = 64'(4 * i);
      #1;
      chk($sformatf("%s_sb%0d", tag, i), 64'(b.instruction), 64'(exp_q.pop_front()));
    end
    for (int i = 0; i < 7; i++) begin
      b.address = tv[i].addr;
      #1;
      chk($sformatf("%s_ins%0d", tag, i), 64'(b.instruction), 64'(tv[i].instr));
      chk($sformatf("%s_flt%0d", tag, i), 64'(b.fetch_fault), 64'(tv[i].fault));
    end
    b.address = '0;
  endtask
  initial begin
    tv[0] = '{64'h0, 32'h91000013, 1'b0};
    tv[1] = '{64'h4, 32'hD2800020, 1'b0};
    tv[2] = '{64'h8, 32'h0, 1'b1};
    tv[3] = '{64'h2, 32'h0, 1'b1};
    tv[4] = '{64'h1_0000_0000, 32'h0, 1'b1};
    tv[5] = '{64'h1000, 32'h0, 1'b1};
    tv[6] = '{64'h5, 32'h0, 1'b1};
    prog = '{8'h13, 8'h00, 8'h00, 8'h91, 8'h20, 8'h00, 8'h80, 8'hD2};
    b.ld_valid = 1'b0;
    b.ld_data = '0;
    b.ld_last = 1'b0;
    b.address = '0;
    b4.ld_valid = 1'b0;
    b4.ld_data = '0;
    b4.ld_last = 1'b0;
    b4.address = '0;
    @(posedge clk);
    #1;
    do_reset();
    chk("rst_ready", 64'(b.ld_ready), 64'd1);
    chk("rst_hold", 64'(b.cpu_hold), 64'd1);
    chk("rst_done", 64'(b.load_done), 64'd0);
    chk("rst_err", 64'(b.load_error), 64'd0);
    chk("rst_wc", 64'(b.word_count), 64'd0);
    chk("rst_flt", 64'(b.fetch_fault), 64'd0);
    chk("rst_ins", 64'(b.instruction), 64'd0);
    load_prog(0);
    check_run("b2b");
    send(8'h77, 1'b1, 0);
    chk("run_ign_wc", 64'(b.word_count), 64'd2);
    do_reset();
    load_prog(1);
    check_run("gap");
    do_reset();
    for (int i = 0; i < 6; i++) send(prog[i], i == 5, 0);
    chk("perr_err", 64'(b.load_error), 64'd1);
    chk("perr_wc", 64'(b.word_count), 64'd1);
    chk("perr_hold", 64'(b.cpu_hold), 64'd1);
    chk("perr_ready", 64'(b.ld_ready), 64'd0);
    chk("perr_done", 64'(b.load_done), 64'd0);
    chk("perr_flt", 64'(b.fetch_fault), 64'd0);
    send(8'h11, 1'b0, 0);
    send(8'h22, 1'b1, 0);
    chk("perr_ign_wc", 64'(b.word_count), 64'd1);
    chk("perr_ign_err", 64'(b.load_error), 64'd1);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      b4.ld_valid = 1'b1;
      b4.ld_data = i == 16 ? 8'hAA : 8'(i + 1);
      @(posedge clk);
      #1;
      b4.ld_valid = 1'b0;
      if (i == 15) begin
        chk("ovf_wc16", 64'(b4.word_count), 64'd4);
        chk("ovf_err16", 64'(b4.load_error), 64'd0);
        chk("ovf_ready16", 64'(b4.ld_ready), 64'd1);
      end
    end
    chk("ovf_err", 64'(b4.load_error), 64'd1);
    chk("ovf_wc", 64'(b4.word_count), 64'd4);
    chk("ovf_mem3", 64'(u4.mem[3]), 64'h100F0E0D);
    do_reset();
    for (int i = 0; i < 5; i++) send(prog[i], 1'b0, 0);
    reset_n = 1'b0;
    b.ld_valid = 1'b1;
    b.ld_data = 8'h55;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    b.ld_valid = 1'b0;
    chk("mid_wc0", 64'(b.word_count), 64'd0);
    chk("mid_ready", 64'(b.ld_ready), 64'd1);
    send(8'hEF, 1'b0, 0);
    send(8'hBE, 1'b0, 0);
    send(8'hAD, 1'b0, 0);
    send(8'hDE, 1'b1, 0);
    chk("mid_wc", 64'(b.word_count), 64'd1);
    chk("mid_done", 64'(b.load_done), 64'd1);
    b.address = 64'h0;
    #1;
    chk("mid_ins0", 64'(b.instruction), 64'hDEADBEEF);
    chk("mid_flt0", 64'(b.fetch_fault), 64'd0);
    b.address = 64'h4;
    #1;
    chk("mid_ins4", 64'(b.instruction), 64'h0);
    chk("mid_flt4", 64'(b.fetch_fault), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
